// File: rtl/ssm_mod_mult.sv
// Interleaved shift-and-subtract modular multiplier, p = (x*y) mod m.
// Scans x MSB-first, one bit per clock, with a start/ready handshake.
module ssm_mod_mult #(
    parameter int N = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] m,
    output logic         ready,
    output logic [N-1:0] p
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  xr;
    logic [N-1:0]  yr;
    logic [N-1:0]  mr;
    logic [N-1:0]  acc;
    logic [CW-1:0] cnt;

    logic [N+1:0]  t0;
    logic [N+1:0]  t1;
    logic [N+1:0]  m2;
    logic [N-1:0]  acc_nxt;

    // Two subtracts suffice: 2*acc + y < 3m whenever acc, y < m.
    always_comb begin
        m2      = {2'b00, mr};
        t0      = {1'b0, acc, 1'b0} + (xr[cnt] ? {2'b00, yr} : '0);
        t1      = (t0 >= m2) ? (t0 - m2) : t0;
        acc_nxt = N'((t1 >= m2) ? (t1 - m2) : t1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            mr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            p     <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        xr    <= x;
                        yr    <= y;
                        mr    <= m;
                        acc   <= '0;
                        cnt   <= CW'(N - 1);
                        ready <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (cnt == '0) begin
                        p     <= acc_nxt;
                        ready <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssm_mod_mult.sv
// Bench for ssm_mod_mult: reference model of (x*y) mod m with N-cycle latency,
// per-cycle compare process, and directed vectors with literal results.
module tb_ssm_mod_mult;

    localparam int N = 128;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] m;
    logic         ready;
    logic [N-1:0] p;

    int compares;
    int errors;

    ssm_mod_mult #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .m     (m),
        .ready (ready),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a job takes N edges after acceptance.
    logic         m_busy;
    logic         m_ready;
    logic [N-1:0] m_p;
    logic [N-1:0] m_exp;
    int           m_left;

    function automatic logic [N-1:0] ref_mod(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input logic [N-1:0] mm);
        logic [2*N-1:0] prod;
        logic [2*N-1:0] r;
        prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        r    = prod % {{N{1'b0}}, mm};
        return r[N-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_p     = '0;
            m_exp   = '0;
            m_left  = 0;
        end else if (!m_busy && start) begin
            m_busy  = 1'b1;
            m_ready = 1'b0;
            m_left  = N;
            m_exp   = ref_mod(x, y, m);
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
                m_p     = m_exp;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            compares++;
            if (ready !== m_ready) begin
                errors++;
                $display("FAIL ready_cycle: got %b want %b at %0t", ready, m_ready, $time);
            end
            if (m_ready) begin
                compares++;
                if (p !== m_p) begin
                    errors++;
                    $display("FAIL p_cycle: got %h want %h at %0t", p, m_p, $time);
                end
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] got,
                         input logic [N-1:0] want);
        compares++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic scramble();
        x = {$urandom, $urandom, $urandom, $urandom};
        y = {$urandom, $urandom, $urandom, $urandom};
        m = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called #1 after a posedge; returns #1 after the edge raising ready.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] mm, input bit hold2,
                          input bit pulse, input bit chk_lit,
                          input logic [N-1:0] lit);
        int cyc;
        x     = a;
        y     = b;
        m     = mm;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("ready_drop", {{(N-1){1'b0}}, ready}, '0);
        cyc = 0;
        if (hold2) begin
            @(posedge clk);
            #1;
            cyc = 1;
        end
        start = 1'b0;
        scramble();
        while (cyc < N + 5) begin
            @(posedge clk);
            cyc++;
            #1;
            if (ready) break;
            if (pulse && cyc == 30) begin
                start = 1'b1;
            end else if (pulse && cyc == 31) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", N'(cyc), N'(N));
        if (chk_lit) begin
            check("p_literal", p, lit);
            check("model_literal", m_p, lit);
        end
    endtask

    logic [N-1:0] rm;
    logic [N-1:0] rx;
    logic [N-1:0] ry;

    initial begin
        compares = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        x        = '0;
        y        = '0;
        m        = '0;
        #20;
        check("reset_ready", {{(N-1){1'b0}}, ready}, '0);
        check("reset_p", p, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(217, 189, 239, 1'b1, 1'b0, 1'b1, 144);
        repeat (6) @(posedge clk);
        #1;
        check("no_second_run", {{(N-1){1'b0}}, ready}, 1);

        run_op(5, 7, 11, 1'b0, 1'b0, 1'b1, 2);
        run_op(0, 100, 239, 1'b0, 1'b0, 1'b1, 0);
        run_op(238, 1, 239, 1'b0, 1'b0, 1'b1, 238);
        run_op({N{1'b1}} - 1, {N{1'b1}} - 1, {N{1'b1}}, 1'b0, 1'b0, 1'b1, 1);
        run_op(3, 4, 5, 1'b0, 1'b0, 1'b1, 2);
        run_op(217, 189, 239, 1'b0, 1'b1, 1'b1, 144);
        run_op(0, 0, 1, 1'b0, 1'b0, 1'b1, 0);

        // Abort mid-operation, then rerun.
        x     = 123;
        y     = 45;
        m     = 239;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {{(N-1){1'b0}}, ready}, '0);
        check("abort_p", p, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(5, 7, 11, 1'b0, 1'b0, 1'b1, 2);

        for (int i = 0; i < 400; i++) begin
            rm = {$urandom, $urandom, $urandom, $urandom};
            rm = rm >> $urandom_range(0, N - 1);
            if (rm == '0) rm = 1;
            rx = {$urandom, $urandom, $urandom, $urandom} % rm;
            ry = {$urandom, $urandom, $urandom, $urandom} % rm;
            run_op(rx, ry, rm, 1'b0, 1'b0, 1'b0, '0);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
